// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter for one slave port, with ready timeout and abort counter
module bus_arbiter #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int tmo_p        = 16,
    parameter int cntw_p       = 8
) (
    input  logic                    main_clk_i,
    input  logic                    main_rst_i,
    input  logic [1:0]              m0_trans_i,
    input  logic [addr_width_p-1:0] m0_addr_i,
    input  logic                    m0_write_i,
    input  logic [data_width_p-1:0] m0_wdata_i,
    output logic                    m0_ready_o,
    output logic                    m0_resp_o,
    output logic [data_width_p-1:0] m0_rdata_o,
    input  logic [1:0]              m1_trans_i,
    input  logic [addr_width_p-1:0] m1_addr_i,
    input  logic                    m1_write_i,
    input  logic [data_width_p-1:0] m1_wdata_i,
    output logic                    m1_ready_o,
    output logic                    m1_resp_o,
    output logic [data_width_p-1:0] m1_rdata_o,
    output logic [1:0]              s_trans_o,
    output logic [addr_width_p-1:0] s_addr_o,
    output logic                    s_write_o,
    output logic [data_width_p-1:0] s_wdata_o,
    input  logic                    s_ready_i,
    input  logic                    s_resp_i,
    input  logic [data_width_p-1:0] s_rdata_i,
    output logic                    busy_o,
    output logic                    owner_o,
    output logic [cntw_p-1:0]       err_cnt_o
);

    typedef enum logic [1:0] {st_idle, st_busy, st_abort} state_e;

    localparam int tw_lp = (tmo_p > 1) ? $clog2(tmo_p) : 1;
    localparam logic [tw_lp-1:0] tmo_last_lp = tw_lp'(tmo_p - 1);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [tw_lp-1:0]   tmo_q, tmo_d;
    logic [cntw_p-1:0]  err_q, err_d;

    logic       req0, req1, grant;
    logic [1:0] owner_trans;

    assign req0        = (m0_trans_i != 2'b00);
    assign req1        = (m1_trans_i != 2'b00);
    // On a tie the master that did not win last time is served.
    assign grant       = (req0 && req1) ? ~last_q : req1;
    assign owner_trans = owner_q ? m1_trans_i : m0_trans_i;

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_q <= st_idle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            tmo_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            st_idle: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    last_d  = grant;
                    tmo_d   = '0;
                    state_d = st_busy;
                end
            end
            st_busy: begin
                // A dropped request ends the transfer silently; it outranks a same-cycle ready.
                if (owner_trans == 2'b00 || s_ready_i) begin
                    state_d = st_idle;
                end else if (tmo_p != 0 && tmo_q == tmo_last_lp) begin
                    state_d = st_abort;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            st_abort: begin
                if (err_q != {cntw_p{1'b1}}) begin
                    err_d = err_q + 1'b1;
                end
                state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase
    end

    always_comb begin
        s_trans_o  = 2'b00;
        s_addr_o   = '0;
        s_write_o  = 1'b0;
        s_wdata_o  = '0;
        m0_ready_o = 1'b0;
        m0_resp_o  = 1'b0;
        m0_rdata_o = '0;
        m1_ready_o = 1'b0;
        m1_resp_o  = 1'b0;
        m1_rdata_o = '0;
        case (state_q)
            st_busy: begin
                s_trans_o = owner_trans;
                s_addr_o  = owner_q ? m1_addr_i  : m0_addr_i;
                s_write_o = owner_q ? m1_write_i : m0_write_i;
                s_wdata_o = owner_q ? m1_wdata_i : m0_wdata_i;
                // Reset in this cycle kills the transfer without a completion pulse.
                if (owner_trans != 2'b00 && s_ready_i && !main_rst_i) begin
                    if (owner_q) begin
                        m1_ready_o = 1'b1;
                        m1_resp_o  = s_resp_i;
                        m1_rdata_o = s_rdata_i;
                    end else begin
                        m0_ready_o = 1'b1;
                        m0_resp_o  = s_resp_i;
                        m0_rdata_o = s_rdata_i;
                    end
                end
            end
            st_abort: begin
                if (!main_rst_i) begin
                    if (owner_q) begin
                        m1_ready_o = 1'b1;
                        m1_resp_o  = 1'b1;
                    end else begin
                        m0_ready_o = 1'b1;
                        m0_resp_o  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_o    = (state_q == st_busy);
    assign owner_o   = owner_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter: vector table, corner sequences, random run against a reference model
module tb_bus_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m0_trans, m1_trans;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_write, m1_write;
    logic        m0_ready, m0_resp, m1_ready, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  s_trans;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_write, s_ready, s_resp;
    logic        busy, owner;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    bus_arbiter #(.addr_width_p(32), .data_width_p(32), .tmo_p(TMO), .cntw_p(8)) dut (
        .main_clk_i(clk), .main_rst_i(rst),
        .m0_trans_i(m0_trans), .m0_addr_i(m0_addr), .m0_write_i(m0_write), .m0_wdata_i(m0_wdata),
        .m0_ready_o(m0_ready), .m0_resp_o(m0_resp), .m0_rdata_o(m0_rdata),
        .m1_trans_i(m1_trans), .m1_addr_i(m1_addr), .m1_write_i(m1_write), .m1_wdata_i(m1_wdata),
        .m1_ready_o(m1_ready), .m1_resp_o(m1_resp), .m1_rdata_o(m1_rdata),
        .s_trans_o(s_trans), .s_addr_o(s_addr), .s_write_o(s_write), .s_wdata_o(s_wdata),
        .s_ready_i(s_ready), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
        .busy_o(busy), .owner_o(owner), .err_cnt_o(err_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: transfer in progress, abort pending, who owns, how many BUSY cycles so far.
    bit mx_in_xfer = 0;
    bit mx_abort   = 0;
    bit mx_owner   = 0;
    bit mx_last    = 1;
    int mx_elapsed = 0;
    int mx_err     = 0;
    bit seen_r0, seen_r1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        logic [1:0] ot;
        bit g;
        ot = mx_owner ? m1_trans : m0_trans;
        if (rst) begin
            mx_in_xfer = 0; mx_abort = 0; mx_owner = 0; mx_last = 1; mx_err = 0;
        end else if (mx_in_xfer) begin
            if (ot == 0 || s_ready) mx_in_xfer = 0;
            else if (mx_elapsed == TMO) begin mx_in_xfer = 0; mx_abort = 1; end
            else mx_elapsed++;
        end else if (mx_abort) begin
            mx_abort = 0;
            if (mx_err < 255) mx_err++;
        end else if (m0_trans != 0 || m1_trans != 0) begin
            g = (m0_trans != 0 && m1_trans != 0) ? !mx_last : (m1_trans != 0);
            mx_owner = g; mx_last = g; mx_in_xfer = 1; mx_elapsed = 1;
        end
    endtask

    // Inputs are already applied; compare against the model, then advance one clock.
    task automatic cycle();
        logic [1:0]   ot;
        logic [127:0] e_s, e_m0, e_m1, e_st;
        #1;
        ot = mx_owner ? m1_trans : m0_trans;
        e_s = '0; e_m0 = '0; e_m1 = '0;
        if (mx_in_xfer) begin
            e_s = mx_owner ? {m1_trans, m1_addr, m1_write, m1_wdata} : {m0_trans, m0_addr, m0_write, m0_wdata};
            if (ot != 0 && s_ready && !rst) begin
                if (mx_owner) e_m1 = {1'b1, s_resp, s_rdata};
                else          e_m0 = {1'b1, s_resp, s_rdata};
            end
        end else if (mx_abort && !rst) begin
            if (mx_owner) e_m1 = {1'b1, 1'b1, 32'h0};
            else          e_m0 = {1'b1, 1'b1, 32'h0};
        end
        e_st = {mx_in_xfer, mx_owner, 8'(mx_err)};
        chk("model_slave", {s_trans, s_addr, s_write, s_wdata}, e_s);
        chk("model_m0", {m0_ready, m0_resp, m0_rdata}, e_m0);
        chk("model_m1", {m1_ready, m1_resp, m1_rdata}, e_m1);
        chk("model_status", {busy, owner, err_cnt}, e_st);
        seen_r0 = m0_ready;
        seen_r1 = m1_ready;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; m0_trans = 0; m1_trans = 0; s_ready = 0; s_resp = 0;
        cycle();
        rst = 0;
    endtask

    task automatic gen_master(input bit seen, inout bit pend, inout logic [1:0] trans,
                              inout logic [31:0] addr, inout logic write, inout logic [31:0] wdata);
        if (pend && (seen || $urandom_range(0, 39) == 0)) pend = 0;
        else if (!pend && $urandom_range(0, 2) == 0) begin
            pend = 1;
            trans = 2'($urandom_range(1, 3));
            addr = $urandom; write = 1'($urandom); wdata = $urandom;
        end
        if (!pend) trans = 2'b00;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  t0, t1;
        logic        srdy, sresp;
        logic [1:0]  e_strans;
        logic        e_busy, e_owner, e_r0, e_resp0, e_r1, e_resp1;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic [1:0] t0, logic [1:0] t1, logic srdy, logic sresp,
                                logic [1:0] es, logic eb, logic eo, logic er0, logic ep0,
                                logic er1, logic ep1, logic [31:0] ed0, logic [31:0] ed1);
        vec_t v;
        v.rst = r; v.t0 = t0; v.t1 = t1; v.srdy = srdy; v.sresp = sresp;
        v.e_strans = es; v.e_busy = eb; v.e_owner = eo; v.e_r0 = er0; v.e_resp0 = ep0;
        v.e_r1 = er1; v.e_resp1 = ep1; v.e_rd0 = ed0; v.e_rd1 = ed1;
        return v;
    endfunction

    initial begin
        bit p0, p1;
        int n;
        localparam logic [31:0] RD = 32'hDEAD_BEEF;

        // single write: ready in 3rd BUSY cycle
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, RD, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // contention from reset, plus read routing to m1 and late ready ignored in IDLE
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2, 1, 0, 1, 1, 0, 1, 0, 0, 0, RD, 0));
        vt.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2, 1, 1, 2, 1, 1, 0, 0, 1, 1, 0, RD));
        vt.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2, 1, 0, 1, 1, 0, 1, 0, 0, 0, RD, 0));
        vt.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2, 1, 1, 2, 1, 1, 0, 0, 1, 1, 0, RD));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        rst = 1; m0_trans = 0; m1_trans = 0; s_ready = 0; s_resp = 0; s_rdata = RD;
        m0_addr = 32'h10; m0_write = 1; m0_wdata = 32'hA5A5_0001;
        m1_addr = 32'h24; m1_write = 0; m1_wdata = 32'h0;
        @(posedge clk); #1;
        chk("reset_state", {s_trans, s_addr, s_write, s_wdata, m0_ready, m0_resp, m0_rdata,
                            m1_ready, m1_resp, m1_rdata, busy, owner, err_cnt}, '0);
        rst = 0;

        foreach (vt[i]) begin
            rst = vt[i].rst; m0_trans = vt[i].t0; m1_trans = vt[i].t1;
            s_ready = vt[i].srdy; s_resp = vt[i].sresp;
            #1;
            chk($sformatf("vec%0d", i),
                {s_trans, busy, owner, m0_ready, m0_resp, m1_ready, m1_resp, m0_rdata, m1_rdata},
                {vt[i].e_strans, vt[i].e_busy, vt[i].e_owner, vt[i].e_r0, vt[i].e_resp0,
                 vt[i].e_r1, vt[i].e_resp1, vt[i].e_rd0, vt[i].e_rd1});
            cycle();
        end

        // timeout abort then saturation of the error counter
        do_reset();
        m0_trans = 1;
        repeat (1 + TMO) cycle();
        #1;
        chk("abort_pulse", {m0_ready, m0_resp, m0_rdata, s_trans, busy}, {1'b1, 1'b1, 32'h0, 2'b00, 1'b0});
        cycle();
        chk("err_after_abort", err_cnt, 8'd1);
        n = 1;
        for (int c = 0; c < 3000 && n < 260; c++) begin
            #1;
            if (m0_ready) n++;
            cycle();
        end
        cycle();
        chk("abort_count", n, 260);
        chk("err_saturated", err_cnt, 8'd255);

        // ready on the last allowed BUSY cycle wins over the timeout
        do_reset();
        m0_trans = 1;
        repeat (TMO) cycle();
        s_ready = 1; s_resp = 0;
        #1;
        chk("bnd_ready", {m0_ready, m0_resp, busy}, {1'b1, 1'b0, 1'b1});
        cycle();
        s_ready = 0; m0_trans = 0;
        #1;
        chk("bnd_no_abort", {m0_ready, busy, err_cnt}, '0);
        cycle();

        // reset in the middle of an m1 transfer
        do_reset();
        m1_trans = 2;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0; m1_trans = 0;
        #1;
        chk("rst_mid_idle", {busy, s_trans, m1_ready, m0_ready}, '0);
        cycle();
        m0_trans = 1; m1_trans = 2;
        cycle();
        #1;
        chk("rst_then_m0", {owner, s_trans, busy}, {1'b0, 2'd1, 1'b1});
        s_ready = 1;
        cycle();
        m0_trans = 0; m1_trans = 0; s_ready = 0;
        cycle();

        // randomized run against the model
        do_reset();
        p0 = 0; p1 = 0; seen_r0 = 0; seen_r1 = 0;
        for (int c = 0; c < 4000; c++) begin
            gen_master(seen_r0, p0, m0_trans, m0_addr, m0_write, m0_wdata);
            gen_master(seen_r1, p1, m1_trans, m1_addr, m1_write, m1_wdata);
            s_ready = ($urandom_range(0, 3) == 0);
            s_resp  = 1'($urandom);
            s_rdata = $urandom;
            rst     = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
